// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA pixel stream
package vga_pkg;

  localparam int H_RES_DEFAULT   = 640;
  localparam int V_RES_DEFAULT   = 480;
  localparam int COLOR_W_DEFAULT = 4;

  typedef struct packed {
    logic [COLOR_W_DEFAULT-1:0] r;
    logic [COLOR_W_DEFAULT-1:0] g;
    logic [COLOR_W_DEFAULT-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FLUSH      = 2'd1,
    FILL       = 2'd2,
    DONE       = 2'd3
  } fetch_state_t;

  function automatic int frame_pixels(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

endpackage

// File: rtl/vga_pixel_stream_fifo.sv
// rtl/vga_pixel_stream_fifo.sv - show-ahead synchronous prefetch FIFO with clear
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int WIDTH = 3 * COLOR_W_DEFAULT,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_pixel,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst_pixel) begin
    if (rst_pixel) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_pixel_stream.sv
// rtl/vga_pixel_stream.sv - framebuffer prefetch and aligned RGB output stage
// Optional colour-bar override when VGA_TEST_PATTERN_EN is defined.
module vga_pixel_stream
  import vga_pkg::*;
#(
  parameter int H_RES      = H_RES_DEFAULT,
  parameter int V_RES      = V_RES_DEFAULT,
  parameter int COLOR_W    = COLOR_W_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19
) (
  input  logic                   clk,
  input  logic                   rst_pixel,
  input  logic [9:0]             sx,
  input  logic [9:0]             sy,
  input  logic                   de,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  output logic                   rd_req_valid,
  output logic [ADDR_W-1:0]      rd_req_addr,
  input  logic                   rd_req_ready,
  input  logic                   rd_data_valid,
  input  logic [3*COLOR_W-1:0]   rd_data,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_de,
  output logic                   underflow
);

  localparam int PIX_W   = 3 * COLOR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_N = frame_pixels(H_RES, V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_N - 1);

  localparam logic [1:0] ST_WAIT_FRAME = WAIT_FRAME;
  localparam logic [1:0] ST_FLUSH      = FLUSH;
  localparam logic [1:0] ST_FILL       = FILL;
  localparam logic [1:0] ST_DONE       = DONE;

  logic [1:0]       state;
  logic             armed;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [PIX_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             frame_start;
  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             pix_ok;
  logic [PIX_W-1:0] fifo_pix;
  logic [PIX_W-1:0] next_pix;

  assign frame_start = (sx == 10'd0) && (sy == 10'(V_RES));
  assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding);

  // Requests stop on the frame-start cycle so no request straddles a flush.
  assign rd_req_valid = (state == ST_FILL) && !frame_start
                        && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign req_fire     = rd_req_valid && rd_req_ready;

  always_ff @(posedge clk or posedge rst_pixel) begin
    if (rst_pixel) begin
      state       <= ST_WAIT_FRAME;
      rd_req_addr <= '0;
      armed       <= 1'b0;
    end else if (frame_start) begin
      state <= ST_FLUSH;
    end else begin
      unique case (state)
        ST_FLUSH: begin
          rd_req_addr <= '0;
          if (outstanding == '0) begin
            state <= ST_FILL;
            armed <= 1'b1;
          end
        end
        ST_FILL: begin
          if (req_fire) begin
            rd_req_addr <= rd_req_addr + 1'b1;
            if (rd_req_addr == LAST_ADDR) state <= ST_DONE;
          end
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_pixel) begin
    if (rst_pixel) begin
      outstanding <= '0;
    end else begin
      unique case ({req_fire, rd_data_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_pixel (rst_pixel),
    .clear     (state == ST_FLUSH),
    .push      (rd_data_valid && (state != ST_FLUSH)),
    .pop       (pix_ok),
    .din       (rd_data),
    .dout      (fifo_dout),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pix_ok   = de && !fifo_empty;
  assign fifo_pix = pix_ok ? fifo_dout : '0;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]       bar;
  logic [PIX_W-1:0] tp_pix;

  assign bar    = sx[9:7];
  assign tp_pix = de ? {{COLOR_W{bar[0]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[2]}}} : '0;
  // The FIFO keeps popping underneath the bars so fetch stays in step.
  assign next_pix = test_pattern ? tp_pix : fifo_pix;
`else
  assign next_pix = fifo_pix;
`endif

  always_ff @(posedge clk or posedge rst_pixel) begin
    if (rst_pixel) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
      vga_de    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vga_r     <= next_pix[3*COLOR_W-1:2*COLOR_W];
      vga_g     <= next_pix[2*COLOR_W-1:COLOR_W];
      vga_b     <= next_pix[COLOR_W-1:0];
      vga_hsync <= hsync_in;
      vga_vsync <= vsync_in;
      vga_de    <= de;
      underflow <= de && fifo_empty && armed;
    end
  end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// tb/tb_vga_pixel_stream.sv - self-checking bench for vga_pixel_stream on a reduced raster
module tb_vga_pixel_stream;

  localparam int H       = 16;
  localparam int V       = 4;
  localparam int HT      = 40;
  localparam int VT      = 7;
  localparam int DEPTH   = 16;
  localparam int FRAME_N = H * V;

  logic        clk = 1'b0;
  logic        rst_pixel;
  logic [9:0]  sx, sy;
  logic        de, hsync_in, vsync_in;
  logic        rd_req_valid;
  logic [7:0]  rd_req_addr;
  logic        rd_req_ready;
  logic        rd_data_valid;
  logic [11:0] rd_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de, underflow;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_pixel_stream #(
    .H_RES(H), .V_RES(V), .COLOR_W(4), .FIFO_DEPTH(DEPTH), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst_pixel(rst_pixel), .sx(sx), .sy(sy), .de(de),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de), .underflow(underflow)
  );

  typedef struct { int addr; int epoch; int due; } mreq_t;
  mreq_t memq[$];

  int tests = 0, fails = 0;
  int cyc = 0, lat = 3, epoch = 0;
  int P = 0, R = 0, issued = 0;
  bit seen_fs = 0, have_exp = 0, prev_stall = 0;
  int prev_addr = 0, last_addr = 0;
  bit last_valid = 0;
  int exp_col = 0;
  bit exp_de = 0, exp_hs = 0, exp_vs = 0, exp_uf = 0;
  int uf_act = 0, uf_blank = 0;

  function automatic int pix(input int a);
    return 12'hA00 | (a & 12'hFF);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: the k-th shown pixel of a frame is address k; a pixel can be shown
  // only once its data returned on an earlier cycle, otherwise black + underflow.
  task automatic step();
    bit fs;
    mreq_t m;
    @(negedge clk);
    last_valid = rd_req_valid;
    last_addr  = int'(rd_req_addr);
    if (rst_pixel) begin
      have_exp = 0;
    end else begin
      fs = (sx == 10'd0) && (sy == 10'(V));
      if (!seen_fs) check("idle_before_frame", int'(rd_req_valid), 0);
      if (seen_fs && issued == FRAME_N && !fs) check("done_no_req", int'(rd_req_valid), 0);
      if (prev_stall && !fs) begin
        check("stall_valid", int'(rd_req_valid), 1);
        check("stall_addr", int'(rd_req_addr), prev_addr);
      end
      prev_stall = rd_req_valid && !rd_req_ready;
      prev_addr  = int'(rd_req_addr);
      if (rd_req_valid && rd_req_ready) begin
        check("req_addr", int'(rd_req_addr), issued);
        memq.push_back('{addr: int'(rd_req_addr), epoch: epoch, due: cyc + lat});
        issued++;
        check("credit_limit", int'((issued - P) <= DEPTH), 1);
      end
      exp_col = 0;
      exp_uf  = 0;
      if (seen_fs && de) begin
        if (P < R) begin
          exp_col = pix(P);
          P++;
        end else begin
          exp_uf = 1;
        end
      end
      exp_de = de;
      exp_hs = hsync_in;
      exp_vs = vsync_in;
      if (rd_data_valid) begin
        m = memq.pop_front();
        if (m.epoch == epoch) R++;
      end
      if (fs) begin
        epoch++;
        P = 0; R = 0; issued = 0;
        seen_fs = 1;
        prev_stall = 0;
      end
      have_exp = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (have_exp) begin
      check("vga_rgb", int'({vga_r, vga_g, vga_b}), exp_col);
      check("vga_de", int'(vga_de), int'(exp_de));
      check("vga_hsync", int'(vga_hsync), int'(exp_hs));
      check("vga_vsync", int'(vga_vsync), int'(exp_vs));
      check("underflow", int'(underflow), int'(exp_uf));
    end
    if (!rst_pixel && memq.size() > 0 && memq[0].due <= cyc) begin
      rd_data_valid = 1'b1;
      rd_data       = 12'(pix(memq[0].addr));
    end else begin
      rd_data_valid = 1'b0;
    end
  endtask

  task automatic drive(input int x, input int y, input int mode);
    sx       = 10'(x);
    sy       = 10'(y);
    de       = (x < H) && (y < V);
    hsync_in = (x >= H + 4) && (x < H + 10);
    vsync_in = (y == V + 1);
    case (mode)
      1:       rd_req_ready = ($urandom_range(0, 3) != 0);
      2:       rd_req_ready = (y >= V) || (y == 0) || (y == 1 && x < 4);
      default: rd_req_ready = 1'b1;
    endcase
    step();
    if (underflow) begin
      if (vga_de) uf_act++;
      else        uf_blank++;
    end
  endtask

  task automatic scan_frame(input int mode, input bit lit, input bit chk_full);
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        drive(x, y, mode);
        if (lit && x == 5 && y == 0) begin
          check("pix_sx5_sy0", int'({vga_r, vga_g, vga_b}), 12'hA05);
          check("de_sx5_sy0", int'(vga_de), 1);
        end
        if (lit && x == 0 && y == 1) check("pix_sx0_sy1", int'({vga_r, vga_g, vga_b}), 12'hA10);
        if (chk_full && x == HT - 1 && y == V - 1) check("frame_pixels", P, FRAME_N);
      end
    end
  endtask

  initial begin
    rst_pixel = 1'b1;
    sx = '0; sy = '0; de = 0; hsync_in = 0; vsync_in = 0;
    rd_req_ready = 1'b1; rd_data_valid = 1'b0; rd_data = '0;
    #1;
    check("reset_outputs", int'({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de, underflow, rd_req_valid}), 0);
    check("reset_addr", int'(rd_req_addr), 0);
    repeat (3) step();
    rst_pixel = 1'b0;

    // Released mid-frame: no requests until the first frame-start.
    for (int y = 2; y < VT; y++)
      for (int x = (y == 2) ? 5 : 0; x < HT; x++) drive(x, y, 0);
    check("prefetch_16", issued, 16);

    scan_frame(0, 0, 1);
    scan_frame(0, 1, 1);

    uf_act = 0; uf_blank = 0;
    scan_frame(2, 0, 0);
    check("uf_seen", int'(uf_act > 0), 1);
    check("uf_blank", uf_blank, 0);

    // Early frame-start with three reads still in flight.
    for (int x = 0; x < HT; x++) drive(x, 0, 0);
    for (int x = 0; x <= 10; x++) drive(x, 1, 0);
    check("inflight_at_fs", memq.size(), 3);
    for (int x = 0; x < HT; x++) begin
      drive(x, V, 0);
      if (x <= 3) check("flush_hold", int'(last_valid), 0);
      if (x == 4) begin
        check("refill_valid", int'(last_valid), 1);
        check("refill_addr", last_addr, 0);
      end
    end
    for (int y = V + 1; y < VT; y++)
      for (int x = 0; x < HT; x++) drive(x, y, 0);
    scan_frame(0, 1, 1);

    uf_act = 0; uf_blank = 0;
    scan_frame(1, 0, 1);
    check("bp_no_underflow", uf_act + uf_blank, 0);

    // Reset mid-frame: outputs clear immediately, fetch waits for a new frame.
    for (int x = 0; x < HT; x++) drive(x, 0, 0);
    for (int x = 0; x <= 8; x++) drive(x, 1, 0);
    rst_pixel = 1'b1;
    #1;
    check("midreset_outputs", int'({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de, underflow, rd_req_valid}), 0);
    check("midreset_addr", int'(rd_req_addr), 0);
    memq.delete();
    rd_data_valid = 1'b0;
    seen_fs = 0; prev_stall = 0; epoch++;
    P = 0; R = 0; issued = 0;
    drive(9, 1, 0);
    drive(10, 1, 0);
    rst_pixel = 1'b0;
    for (int y = 1; y < VT; y++)
      for (int x = (y == 1) ? 11 : 0; x < HT; x++) drive(x, y, 0);
    scan_frame(0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
